memory_stage: RTL and testbench

Pipeline memory (M) stage. It registers the execute-stage bundle, performs at most one data-memory access per instruction over a req/ack handshake with arbitrary wait states, and reports busy to the hazard unit while the access is outstanding. It forms the 103-bit bundle consumed by the writeback stage: {regWrite, memToReg, readData, aluOut, writeReg, instr}.

---
 rtl/memory_stage.sv | 130 +++++++++++++
 tb/tb_memory_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// memory_stage: M-stage pipeline register plus at most one data-memory access per instruction
// over a req/ack handshake with arbitrary wait states; memBusy_M stalls upstream while waiting.
module memory_stage #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_M,
  input  logic             flush_M,
  input  logic [103:0]     buffIn_M,
  output logic [102:0]     buffOut_M,
  output logic             regWrite_M,
  output logic [4:0]       writeReg_M,
  output logic [width-1:0] aluOut_M,
  output logic             memBusy_M,
  output logic             misalign_M,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [width-1:0] dmem_addr,
  output logic [width-1:0] dmem_wdata,
  input  logic [width-1:0] dmem_rdata,
  input  logic             dmem_ack
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DRAIN} state_t;
  state_t state;

  logic             m_rw, m_mtr, m_we;
  logic [width-1:0] m_alu, m_wd;
  logic [4:0]       m_wr;
  logic [31:0]      m_instr;
  logic [width-1:0] rdata_q, sh_addr, sh_wdata;
  logic             sh_we, mis_q;

  logic             in_rw, in_mtr, in_mw, in_memop, in_mis, in_go, load;
  logic [width-1:0] in_alu, in_wd;
  logic [4:0]       in_wr;
  logic [31:0]      in_instr;
  logic [width-1:0] rd;

  assign {in_rw, in_mtr, in_mw, in_alu, in_wd, in_wr, in_instr} = buffIn_M;

  assign in_memop  = in_mw | in_mtr;
  assign in_mis    = in_memop & (in_alu[1:0] != 2'b00);
  assign in_go     = in_memop & ~in_mis;

  assign memBusy_M = ((state == REQ) & ~dmem_ack) | (state == DRAIN);
  assign load      = ~flush_M & ~stall_M & ~memBusy_M;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      m_rw     <= 1'b0;
      m_mtr    <= 1'b0;
      m_we     <= 1'b0;
      m_alu    <= '0;
      m_wd     <= '0;
      m_wr     <= '0;
      m_instr  <= '0;
      rdata_q  <= '0;
      sh_we    <= 1'b0;
      sh_addr  <= '0;
      sh_wdata <= '0;
      mis_q    <= 1'b0;
    end else begin
      mis_q <= 1'b0;
      if (state == REQ && dmem_ack) rdata_q <= dmem_rdata;

      if (flush_M) begin
        m_rw    <= 1'b0;
        m_mtr   <= 1'b0;
        m_we    <= 1'b0;
        m_alu   <= '0;
        m_wd    <= '0;
        m_wr    <= '0;
        m_instr <= '0;
      end else if (load) begin
        // a dropped misaligned access must not write the register file
        m_rw    <= in_rw & ~in_mis;
        m_mtr   <= in_mtr & ~in_mw & ~in_mis;
        m_we    <= in_mw;
        m_alu   <= in_alu;
        m_wd    <= in_wd;
        m_wr    <= in_wr;
        m_instr <= in_instr;
        mis_q   <= in_mis;
      end

      case (state)
        IDLE, HOLD: begin
          if (flush_M)   state <= IDLE;
          else if (load) state <= in_go ? REQ : IDLE;
        end
        REQ: begin
          if (dmem_ack) begin
            if (flush_M)      state <= IDLE;
            else if (stall_M) state <= HOLD;
            else              state <= in_go ? REQ : IDLE;
          end else if (flush_M) begin
            // the request cannot be withdrawn; keep presenting it from shadow copies
            state    <= DRAIN;
            sh_we    <= m_we;
            sh_addr  <= m_alu;
            sh_wdata <= m_wd;
          end
        end
        DRAIN: begin
          if (dmem_ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dmem_req   = (state == REQ) | (state == DRAIN);
  assign dmem_we    = (state == DRAIN) ? sh_we : ((state == REQ) & m_we);
  assign dmem_addr  = (state == DRAIN) ? sh_addr : m_alu;
  assign dmem_wdata = (state == DRAIN) ? sh_wdata : m_wd;

  assign rd = !m_mtr            ? '0 :
              (state == REQ)    ? dmem_rdata :
              (state == HOLD)   ? rdata_q : '0;

  assign buffOut_M  = {m_rw & ~memBusy_M, m_mtr & ~memBusy_M, rd, m_alu, m_wr, m_instr};
  assign regWrite_M = m_rw & ~memBusy_M;
  assign writeReg_M = m_wr;
  assign aluOut_M   = m_alu;
  assign misalign_M = mis_q;

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios plus random traffic against a flag-level reference model.
module tb_memory_stage;

  typedef struct packed {
    logic        rw;
    logic        mtr;
    logic        mw;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic [31:0] ins;
  } ins_t;

  logic         clk = 1'b0;
  logic         reset, stall_M, flush_M, dmem_ack;
  logic [103:0] buffIn_M;
  logic [102:0] buffOut_M;
  logic         regWrite_M, memBusy_M, misalign_M, dmem_req, dmem_we;
  logic [4:0]   writeReg_M;
  logic [31:0]  aluOut_M, dmem_addr, dmem_wdata, dmem_rdata;

  int total = 0;
  int bad   = 0;

  // reference model: the held instruction plus the status of its memory access
  ins_t        h;
  bit          m_open, m_orph, m_fresh, o_we;
  logic [31:0] got, o_addr, o_wd;

  memory_stage #(.width(32)) dut (
    .clk(clk), .reset(reset), .stall_M(stall_M), .flush_M(flush_M),
    .buffIn_M(buffIn_M), .buffOut_M(buffOut_M), .regWrite_M(regWrite_M),
    .writeReg_M(writeReg_M), .aluOut_M(aluOut_M), .memBusy_M(memBusy_M),
    .misalign_M(misalign_M), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
    .dmem_ack(dmem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [103:0] act, input logic [103:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic ins_t mk(bit rw, bit mtr, bit mw, logic [31:0] alu, logic [31:0] wd, logic [4:0] wr);
    ins_t t;
    t.rw = rw; t.mtr = mtr; t.mw = mw; t.alu = alu; t.wd = wd; t.wr = wr;
    t.ins = 32'h0A00_0000 ^ alu;
    return t;
  endfunction

  function automatic ins_t rnd_ins();
    ins_t t;
    t.rw = 1'($urandom); t.mtr = 1'b0; t.mw = 1'b0;
    t.alu = $urandom; t.wd = $urandom; t.wr = 5'($urandom); t.ins = $urandom;
    if ($urandom_range(0, 5) != 0) t.alu[1:0] = 2'b00;
    case ($urandom_range(0, 3))
      0: t.rw = 1'b1;
      1: t.mtr = 1'b1;
      2: begin t.mw = 1'b1; t.mtr = 1'($urandom); end
      default: ;
    endcase
    return t;
  endfunction

  // one clock cycle: drive inputs, compare against the model, then advance the model over the edge
  task automatic step(input bit rst_n, input bit fl, input bit st, input ins_t din,
                      input bit ack, input logic [31:0] rdat);
    bit req_e, ack_e, stall_e, busy_e, pend, mem_e, mis_e, ld_e, wr_e;
    logic [31:0] rd_e;
    @(posedge clk); #1;
    req_e   = m_open | m_orph;
    ack_e   = ack & req_e;
    stall_e = st | (m_open & ~ack_e);
    reset = rst_n; flush_M = fl; stall_M = stall_e; buffIn_M = din;
    dmem_ack = ack_e; dmem_rdata = rdat;
    @(negedge clk);
    busy_e = (m_open & ~ack_e) | m_orph;
    mem_e  = h.mw | h.mtr;
    mis_e  = mem_e & (h.alu[1:0] != 2'b00);
    ld_e   = h.mtr & ~h.mw & ~mis_e;
    wr_e   = h.rw & ~mis_e;
    rd_e   = !ld_e ? 32'h0 : (m_open ? rdat : got);
    chk("req", dmem_req, req_e);
    chk("busy", memBusy_M, busy_e);
    chk("misalign", misalign_M, m_fresh & mis_e);
    if (req_e) begin
      chk("we", dmem_we, m_orph ? o_we : h.mw);
      chk("addr", dmem_addr, m_orph ? o_addr : h.alu);
      chk("wdata", dmem_wdata, m_orph ? o_wd : h.wd);
    end
    chk("bo_regwrite", buffOut_M[102], wr_e & ~busy_e);
    chk("bo_memtoreg", buffOut_M[101], ld_e & ~busy_e);
    if (!busy_e) chk("bo_readdata", buffOut_M[100:69], rd_e);
    chk("bo_tail", buffOut_M[68:0], {h.alu, h.wr, h.ins});
    chk("fwd_regwrite", regWrite_M, wr_e & ~busy_e);
    chk("fwd_wreg", writeReg_M, h.wr);
    chk("fwd_alu", aluOut_M, h.alu);

    pend = m_open & ~ack_e;
    if (!rst_n) begin
      h = '0; m_open = 0; m_orph = 0; m_fresh = 0; got = '0;
    end else begin
      if (ack_e) begin
        if (m_open) got = rdat;
        m_open = 0;
        m_orph = 0;
      end
      m_fresh = 0;
      if (fl) begin
        if (pend) begin
          m_orph = 1; o_we = h.mw; o_addr = h.alu; o_wd = h.wd;
        end
        h = '0;
        m_open = 0;
      end else if (!stall_e && !busy_e) begin
        h = din;
        m_fresh = 1;
        m_open = (din.mw | din.mtr) && (din.alu[1:0] == 2'b00);
      end
    end
  endtask

  initial begin
    ins_t nop;
    nop = '0;
    h = '0; m_open = 0; m_orph = 0; m_fresh = 0; got = '0; o_we = 0; o_addr = '0; o_wd = '0;
    reset = 1'b0; stall_M = 1'b0; flush_M = 1'b0; dmem_ack = 1'b0;
    buffIn_M = '0; dmem_rdata = '0;
    repeat (2) @(posedge clk);

    // reset state
    step(0, 0, 0, nop, 0, 32'h0);
    chk("rst_bundle", buffOut_M, 103'h0);
    chk("rst_req", dmem_req, 1'b0);

    // non-memory ALU op
    step(1, 0, 0, mk(1, 0, 0, 32'h10, 32'h0, 5'd5), 0, 32'h0);
    step(1, 0, 0, nop, 0, 32'h0);
    chk("alu_rw", buffOut_M[102], 1'b1);
    chk("alu_out", buffOut_M[68:37], 32'h10);
    chk("alu_rd", buffOut_M[100:69], 32'h0);
    chk("alu_req", dmem_req, 1'b0);

    // load, zero wait states
    step(1, 0, 0, mk(1, 1, 0, 32'h100, 32'h0, 5'd7), 0, 32'h0);
    step(1, 0, 0, nop, 1, 32'hDEADBEEF);
    chk("ld0_rd", buffOut_M[100:69], 32'hDEADBEEF);
    chk("ld0_mtr", buffOut_M[101], 1'b1);
    chk("ld0_busy", memBusy_M, 1'b0);

    // store, three wait states
    step(1, 0, 0, mk(0, 0, 1, 32'h200, 32'h1234, 5'd0), 0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, nop, 0, 32'h0);
      chk("st_busy", memBusy_M, 1'b1);
      chk("st_addr", dmem_addr, 32'h200);
      chk("st_wdata", dmem_wdata, 32'h1234);
      chk("st_we", dmem_we, 1'b1);
    end
    step(1, 0, 0, nop, 1, 32'h0);
    chk("st_ackbusy", memBusy_M, 1'b0);
    chk("st_rw", buffOut_M[102], 1'b0);

    // flush mid-access: drain the abandoned load, then accept a new one
    step(1, 0, 0, mk(1, 1, 0, 32'h300, 32'h0, 5'd3), 0, 32'h0);
    step(1, 0, 0, nop, 0, 32'h0);
    step(1, 1, 0, nop, 0, 32'h0);
    step(1, 0, 0, mk(1, 0, 0, 32'h44, 32'h0, 5'd4), 0, 32'h0);
    chk("dr_req", dmem_req, 1'b1);
    chk("dr_addr", dmem_addr, 32'h300);
    chk("dr_busy", memBusy_M, 1'b1);
    step(1, 0, 0, mk(1, 0, 0, 32'h44, 32'h0, 5'd4), 1, 32'hDEADBEEF);
    chk("dr_rw", buffOut_M[102], 1'b0);
    step(1, 0, 0, mk(1, 1, 0, 32'h104, 32'h0, 5'd8), 0, 32'h0);
    chk("dr_idle_req", dmem_req, 1'b0);
    chk("dr_noload", aluOut_M, 32'h0);
    step(1, 0, 0, nop, 1, 32'h55);
    chk("dr_next_rd", buffOut_M[100:69], 32'h55);

    // misaligned load is dropped
    step(1, 0, 0, mk(1, 1, 0, 32'h102, 32'h0, 5'd9), 0, 32'h0);
    step(1, 0, 0, nop, 0, 32'h0);
    chk("mis_pulse", misalign_M, 1'b1);
    chk("mis_req", dmem_req, 1'b0);
    chk("mis_rw", buffOut_M[102], 1'b0);
    step(1, 0, 0, nop, 0, 32'h0);
    chk("mis_once", misalign_M, 1'b0);

    // reset during a pending request
    step(1, 0, 0, mk(1, 1, 0, 32'h400, 32'h0, 5'd10), 0, 32'h0);
    step(1, 0, 0, nop, 0, 32'h0);
    step(0, 0, 0, nop, 0, 32'h0);
    step(1, 0, 0, mk(1, 1, 0, 32'h108, 32'h0, 5'd11), 0, 32'h0);
    chk("rr_req", dmem_req, 1'b0);
    chk("rr_bundle", buffOut_M, 103'h0);
    step(1, 0, 0, nop, 0, 32'h0);
    step(1, 0, 0, nop, 1, 32'hCAFE0001);
    chk("rr_rd", buffOut_M[100:69], 32'hCAFE0001);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 199) != 0, $urandom_range(0, 11) == 0, $urandom_range(0, 3) == 0,
           rnd_ins(), $urandom_range(0, 2) == 0, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
